// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared mode encodings, RGB332 colours and default active area
package vga_pkg;

   localparam int H_ACTIVE_DEFAULT = 640;
   localparam int V_ACTIVE_DEFAULT = 480;

   typedef enum logic [1:0] {
      MODE_BARS     = 2'd0,
      MODE_CHECKER  = 2'd1,
      MODE_GRADIENT = 2'd2,
      MODE_BOUNCE   = 2'd3
   } mode_t;

   // RGB332: {R[2:0], G[2:0], B[1:0]}
   localparam logic [7:0] WHITE   = 8'hFF;
   localparam logic [7:0] YELLOW  = 8'hFC;
   localparam logic [7:0] CYAN    = 8'h1F;
   localparam logic [7:0] GREEN   = 8'h1C;
   localparam logic [7:0] MAGENTA = 8'hE3;
   localparam logic [7:0] RED     = 8'hE0;
   localparam logic [7:0] BLUE    = 8'h03;
   localparam logic [7:0] BLACK   = 8'h00;
   localparam logic [7:0] DKBLUE  = 8'h02;

endpackage

// File: rtl/vga_bounce_axis.sv
// rtl/vga_bounce_axis.sv - one axis of the bouncing box: position and direction,
// clamped and reflected at the edges of the active area on each frame strobe
module vga_bounce_axis #(
   parameter int EXTENT = 640,
   parameter int SIZE   = 32,
   parameter int STEP   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_strobe,
   output logic [9:0] o_pos
);

   localparam logic [10:0] LIMIT  = 11'(EXTENT - SIZE);
   localparam logic [10:0] STEP11 = 11'(STEP);
   localparam logic [9:0]  STEP10 = 10'(STEP);

   logic [9:0]  r_pos;
   logic        r_dir_neg;
   logic [10:0] w_pos11;

   // 11-bit compare so pos+STEP near the top of the range cannot wrap
   assign w_pos11 = {1'b0, r_pos};
   assign o_pos   = r_pos;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pos     <= '0;
         r_dir_neg <= 1'b0;
      end else if (i_strobe) begin
         if (!r_dir_neg) begin
            if (w_pos11 + STEP11 >= LIMIT) begin
               r_pos     <= LIMIT[9:0];
               r_dir_neg <= 1'b1;
            end else begin
               r_pos <= r_pos + STEP10;
            end
         end else begin
            if (w_pos11 <= STEP11) begin
               r_pos     <= '0;
               r_dir_neg <= 1'b0;
            end else begin
               r_pos <= r_pos - STEP10;
            end
         end
      end
   end

endmodule

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - RGB332 test-pattern source for vga_controller (bars, checker,
// gradient, bouncing box); PATTERN_GEN_AUTOCYCLE_EN also advances the mode every 256 frames
module vga_pattern_gen
   import vga_pkg::*;
#(
   parameter int         H_ACTIVE    = H_ACTIVE_DEFAULT,
   parameter int         V_ACTIVE    = V_ACTIVE_DEFAULT,
   parameter int         BOX_SIZE    = 32,
   parameter int         BOX_STEP    = 2,
   parameter int         CHECK_SHIFT = 5,
   parameter logic [7:0] BOX_COLOR   = YELLOW
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] i_x,
   input  logic [9:0] i_y,
   input  logic       i_vsync,
   input  logic       i_mode_next,
   output logic [7:0] o_rgb,
   output logic [1:0] o_mode,
   output logic       o_frame_strobe,
   output logic [7:0] o_frame_cnt
);

   localparam int BAR_W = H_ACTIVE / 8;

   logic [7:0]  r_rgb;
   mode_t       r_mode;
   logic        r_strobe;
   logic [7:0]  r_frame_cnt;
   logic        r_vsync_d;
   logic        r_mode_d;
   logic        r_pending;

   logic        w_mode_edge;
   logic        w_advance;
   logic [9:0]  w_box_x;
   logic [9:0]  w_box_y;
   logic [10:0] w_x11;
   logic [10:0] w_y11;
   logic [9:0]  w_cx;
   logic        w_active;
   logic        w_in_box;
   logic [7:0]  w_bar;
   logic [7:0]  w_pix;

   assign o_rgb          = r_rgb;
   assign o_mode         = r_mode;
   assign o_frame_strobe = r_strobe;
   assign o_frame_cnt    = r_frame_cnt;

   assign w_mode_edge = i_mode_next & ~r_mode_d;
`ifdef PATTERN_GEN_AUTOCYCLE_EN
   assign w_advance   = r_pending | w_mode_edge | (r_frame_cnt == 8'hFF);
`else
   assign w_advance   = r_pending | w_mode_edge;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vsync_d   <= 1'b1;
         r_mode_d    <= 1'b0;
         r_strobe    <= 1'b0;
         r_frame_cnt <= '0;
         r_mode      <= MODE_BARS;
         r_pending   <= 1'b0;
      end else begin
         r_vsync_d <= i_vsync;
         r_mode_d  <= i_mode_next;
         r_strobe  <= r_vsync_d & ~i_vsync;
         // Mode only changes at a frame boundary so a pattern never switches mid-image
         if (r_strobe) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
            r_pending   <= 1'b0;
            if (w_advance) r_mode <= mode_t'(r_mode + 2'd1);
         end else if (w_mode_edge) begin
            r_pending <= 1'b1;
         end
      end
   end

   vga_bounce_axis #(.EXTENT(H_ACTIVE), .SIZE(BOX_SIZE), .STEP(BOX_STEP)) u_axis_x (
      .clk(clk), .rst(rst), .i_strobe(r_strobe), .o_pos(w_box_x)
   );

   vga_bounce_axis #(.EXTENT(V_ACTIVE), .SIZE(BOX_SIZE), .STEP(BOX_STEP)) u_axis_y (
      .clk(clk), .rst(rst), .i_strobe(r_strobe), .o_pos(w_box_y)
   );

   assign w_x11    = {1'b0, i_x};
   assign w_y11    = {1'b0, i_y};
   assign w_cx     = i_x + {2'b00, r_frame_cnt};
   assign w_active = (w_x11 < 11'(H_ACTIVE)) && (w_y11 < 11'(V_ACTIVE));
   assign w_in_box = (w_x11 >= {1'b0, w_box_x}) && (w_x11 < {1'b0, w_box_x} + 11'(BOX_SIZE)) &&
                     (w_y11 >= {1'b0, w_box_y}) && (w_y11 < {1'b0, w_box_y} + 11'(BOX_SIZE));

   always_comb begin
      w_bar = BLACK;
      if      (w_x11 < 11'(1 * BAR_W)) w_bar = WHITE;
      else if (w_x11 < 11'(2 * BAR_W)) w_bar = YELLOW;
      else if (w_x11 < 11'(3 * BAR_W)) w_bar = CYAN;
      else if (w_x11 < 11'(4 * BAR_W)) w_bar = GREEN;
      else if (w_x11 < 11'(5 * BAR_W)) w_bar = MAGENTA;
      else if (w_x11 < 11'(6 * BAR_W)) w_bar = RED;
      else if (w_x11 < 11'(7 * BAR_W)) w_bar = BLUE;
   end

   always_comb begin
      w_pix = BLACK;
      case (r_mode)
         MODE_BARS:     w_pix = w_bar;
         MODE_CHECKER:  w_pix = (w_cx[CHECK_SHIFT] ^ i_y[CHECK_SHIFT]) ? WHITE : BLACK;
         MODE_GRADIENT: w_pix = {i_x[9:7], i_y[8:6], r_frame_cnt[5:4]};
         MODE_BOUNCE:   w_pix = w_in_box ? BOX_COLOR : DKBLUE;
         default:       w_pix = BLACK;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_rgb <= '0;
      else     r_rgb <= w_active ? w_pix : BLACK;
   end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - directed bench with a pixel scoreboard and frame-level reference model
module tb_vga_pattern_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] i_x = '0;
   logic [9:0] i_y = '0;
   logic       i_vsync = 1'b1;
   logic       i_mode_next = 1'b0;
   logic [7:0] o_rgb;
   logic [1:0] o_mode;
   logic       o_frame_strobe;
   logic [7:0] o_frame_cnt;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   int m_cnt, m_mode, m_pend, m_bx, m_by, m_dx, m_dy;

   vga_pattern_gen dut (
      .clk(clk), .rst(rst), .i_x(i_x), .i_y(i_y), .i_vsync(i_vsync),
      .i_mode_next(i_mode_next), .o_rgb(o_rgb), .o_mode(o_mode),
      .o_frame_strobe(o_frame_strobe), .o_frame_cnt(o_frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_mode = 0; m_pend = 0;
      m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
      exp_q.delete();
   endtask

   task automatic axis_step(inout int p, inout int d, input int ext);
      if (d > 0) begin
         if (p + 2 >= ext - 32) begin p = ext - 32; d = -1; end
         else p = p + 2;
      end else begin
         if (p <= 2) begin p = 0; d = 1; end
         else p = p - 2;
      end
   endtask

   function automatic logic [7:0] exp_rgb(input int x, input int y);
      logic [7:0] bars[8];
      logic [9:0] xv, yv, sx;
      logic [7:0] cv;
      bars = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
      xv = 10'(x); yv = 10'(y); cv = 8'(m_cnt);
      sx = 10'((x + m_cnt) % 1024);
      if (x >= 640 || y >= 480) return 8'h00;
      case (m_mode)
         0: return bars[x / 80];
         1: return (sx[5] ^ yv[5]) ? 8'hFF : 8'h00;
         2: return {xv[9:7], yv[8:6], cv[5:4]};
         default: return (x >= m_bx && x < m_bx + 32 && y >= m_by && y < m_by + 32) ? 8'hFC : 8'h02;
      endcase
   endfunction

   task automatic pix(input int x, input int y);
      @(negedge clk);
      i_x = 10'(x); i_y = 10'(y);
      exp_q.push_back(exp_rgb(x, y));
      @(negedge clk);
      check($sformatf("rgb(%0d,%0d)", x, y), {24'b0, o_rgb}, {24'b0, exp_q.pop_front()});
   endtask

   task automatic pulse();
      @(negedge clk) i_mode_next = 1'b1;
      @(negedge clk) i_mode_next = 1'b0;
      m_pend = 1;
   endtask

   // with_pulse raises i_mode_next in the very cycle the strobe is high
   task automatic strobe(input bit with_pulse);
      bit adv;
      @(negedge clk) i_vsync = 1'b0;
      @(negedge clk);
      check("strobe_hi", {31'b0, o_frame_strobe}, 32'd1);
      i_vsync = 1'b1;
      if (with_pulse) i_mode_next = 1'b1;
      adv = (m_pend != 0) || with_pulse;
`ifdef PATTERN_GEN_AUTOCYCLE_EN
      if (m_cnt == 255) adv = 1'b1;
`endif
      if (adv) m_mode = (m_mode + 1) % 4;
      m_pend = 0;
      m_cnt = (m_cnt + 1) % 256;
      axis_step(m_bx, m_dx, 640);
      axis_step(m_by, m_dy, 480);
      @(negedge clk);
      i_mode_next = 1'b0;
      check("strobe_lo", {31'b0, o_frame_strobe}, 32'd0);
      check("frame_cnt", {24'b0, o_frame_cnt}, 32'(m_cnt));
      check("mode", {30'b0, o_mode}, 32'(m_mode));
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_rgb", {24'b0, o_rgb}, 32'd0);
      check("rst_mode", {30'b0, o_mode}, 32'd0);
      check("rst_strobe", {31'b0, o_frame_strobe}, 32'd0);
      check("rst_cnt", {24'b0, o_frame_cnt}, 32'd0);
      rst = 1'b0;

      for (int x = 0; x < 640; x++) pix(x, 0);
      pix(640, 0); pix(0, 480); pix(1023, 1023); pix(639, 479);

      pulse();
      check("mode_hold", {30'b0, o_mode}, 32'd0);
      pulse(); pulse();
      check("mode_hold3", {30'b0, o_mode}, 32'd0);
      strobe(0);
      strobe(0);

      pix(29, 0); pix(30, 0); pix(30, 32); pix(640, 5);
      while (m_cnt != 0) strobe(0);
      pix(31, 0); pix(32, 0); pix(31, 32);
      strobe(0);
      pix(31, 0); pix(30, 0); pix(200, 300);

      strobe(1);
      pix(100, 100); pix(640, 100);
      while (m_mode != 3) begin
         pulse();
         strobe(0);
      end

      repeat (300) begin
         strobe(0);
         pix(m_bx, m_by);
         pix(m_bx + 31, m_by + 31);
         pix(m_bx + 32, m_by);
         pix(m_bx, m_by + 32);
         if (m_bx > 0) pix(m_bx - 1, m_by);
      end
      pix(640, 0); pix(0, 480);

      pix(m_bx, m_by);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_rgb", {24'b0, o_rgb}, 32'd0);
      check("arst_mode", {30'b0, o_mode}, 32'd0);
      check("arst_cnt", {24'b0, o_frame_cnt}, 32'd0);
      check("arst_strobe", {31'b0, o_frame_strobe}, 32'd0);
      model_reset();
      @(negedge clk) rst = 1'b0;
      strobe(0);
      while (m_mode != 3) begin
         pulse();
         strobe(0);
      end
      pix(m_bx, m_by); pix(m_bx + 32, m_by + 32); pix(0, 0); pix(m_bx + 31, m_by);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Upstream pixel source for vga_controller. It takes the controller's pixel coordinates (o_x, o_y) and vsync, and returns an RGB332 byte for the controller's i_rgb input. It provides four selectable test patterns, including one animated bouncing box. Pattern state updates once per frame, so there is no tearing.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
BOX_SIZE, 32, bouncing-box edge length in pixels
BOX_STEP, 2, box displacement per frame per axis, in pixels
CHECK_SHIFT, 5, log2 of checker square size
BOX_COLOR, 8'hFC, box colour in RGB332 (yellow)

Ports:
clk  in  1  pixel clock, same clock as vga_controller
rst  in  1  asynchronous, active-high reset
i_x  in  10  current pixel x, from controller o_x
i_y  in  10  current pixel y, from controller o_y
i_vsync  in  1  controller vsync (active-low pulse)
i_mode_next  in  1  level input; each rising edge requests the next pattern
o_rgb  out  8  pixel colour, {R[2:0],G[2:0],B[1:0]}, to controller i_rgb
o_mode  out  2  currently displayed pattern
o_frame_strobe  out  1  one-cycle pulse on detected frame boundary
o_frame_cnt  out  8  free-running frame counter, wraps 255->0

Behaviour:
- Reset (async assert, sync release) values:
  - o_rgb=0, o_mode=0, o_frame_strobe=0, o_frame_cnt=0.
  - box_x=0, box_y=0, dir_x=+, dir_y=+, pending=0.
  - vsync_d=1, mode_d=0.
- Frame strobe: vsync_d <= i_vsync. Strobe fires when vsync_d=1 and i_vsync=0 (falling edge). The strobe is registered, so o_frame_strobe rises 1 cycle after the edge. o_frame_cnt increments on the strobe.
- Mode request: a rising edge of i_mode_next (mode_d=0, input=1) sets pending.
  - On the strobe with pending=1: o_mode <= o_mode+1 (3 wraps to 0), pending cleared.
  - An edge in the same cycle as the strobe is applied at that strobe.
  - Multiple edges within one frame collapse to a single advance.
- Patterns, selected by o_mode; o_rgb is registered and appears 1 clk after i_x/i_y:
  - 0 COLOR_BARS: 8 bars, each W=H_ACTIVE/8 wide (elaboration constant). Index by comparator chain, no divider. Colours in order: FF, FC, 1F, 1C, E3, E0, 03, 00.
  - 1 CHECKER: bit CHECK_SHIFT of (i_x+o_frame_cnt) XOR bit CHECK_SHIFT of i_y. 1 -> FF, 0 -> 00. The 10-bit add wraps.
  - 2 GRADIENT: {i_x[9:7], i_y[8:6], o_frame_cnt[5:4]}.
  - 3 BOUNCE: BOX_COLOR when box_x<=i_x<box_x+BOX_SIZE and box_y<=i_y<box_y+BOX_SIZE; else 8'h02.
- Active gating: if i_x>=H_ACTIVE or i_y>=V_ACTIVE, o_rgb <= 0.
- Box update: on the strobe only, and in every mode. x axis shown; y is identical with V_ACTIVE.
  - dir + and box_x+BOX_STEP >= H_ACTIVE-BOX_SIZE: clamp box_x=H_ACTIVE-BOX_SIZE, dir_x <= -.
  - dir - and box_x <= BOX_STEP: clamp box_x=0, dir_x <= +.
  - Otherwise box_x moves BOX_STEP in direction dir_x.
  - Comparisons use 11-bit arithmetic, so there is no 10-bit overflow.
- Latency note: the 1-clk output latency shifts the image 1 pixel right. This is accepted; the controller blanks outside its active region.
- Reset mid-frame: all state returns to reset values immediately. The first strobe after release counts as frame 1.

Optional Feature:
PATTERN_GEN_AUTOCYCLE_EN
- Defined: o_mode also advances automatically on every strobe where o_frame_cnt==8'hFF (i.e. each 256 frames).
  - If this coincides with pending, the advance happens once and pending is cleared.
- Undefined: the mode changes only via i_mode_next; no extra logic is generated.

Decomposition:
- Package vga_pkg:
  - Mode encodings: MODE_BARS=0, MODE_CHECKER=1, MODE_GRADIENT=2, MODE_BOUNCE=3.
  - RGB332 colour constants: WHITE, YELLOW, CYAN, GREEN, MAGENTA, RED, BLUE, BLACK, DKBLUE.
  - Default H_ACTIVE and V_ACTIVE.
- Sub-module vga_bounce_axis:
  - Holds one axis position and direction, with the clamp/flip update on strobe.
  - Parameterized by extent (H_ACTIVE or V_ACTIVE), BOX_SIZE and BOX_STEP.
  - Instantiated twice (x, y).

Test Plan:
- Reset, mode 0, sweep i_x 0..639 at i_y=0 -> o_rgb one clk later: FF for x 0..79, FC for 80..159, and so on; 00 for x 560..639.
- i_mode_next pulse mid-frame -> o_mode stays 0 until the next vsync falling edge, then becomes 1. Three pulses in one frame -> advance by 1 only.
- Mode 3, 300 strobes -> box_x sequence 0,2,...,606,608,606. dir_x flips exactly at 608 and box_x never exceeds 608. Same check for box_y at 448.
- Mode 1, o_frame_cnt=0, i_x=31/32 at i_y=0 -> 00/FF. After 1 strobe, i_x=31 -> FF.
- i_x=640 or i_y=480 in any mode -> o_rgb=00. Assert rst mid-line -> o_rgb=0, o_mode=0, box at (0,0) asynchronously.
- With PATTERN_GEN_AUTOCYCLE_EN, 256 strobes -> o_mode 0->1 on the strobe where o_frame_cnt wraps FF->00. Without the macro -> o_mode stays 0.
